// File: rtl/sr_drv_pkg.sv
// Shared types and sizing helpers for the SR latch write driver.
// Holds the FSM encoding and parameter floors.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GUARD,
    CHECK
  } state_t;

  localparam int PULSE_W_MIN = 1;
  localparam int GUARD_W_MIN = 2;

  function automatic int cnt_w(
    input int pw,
    input int gw
  );
    int m;
    m = (pw > gw) ? pw : gw;
    if (m < 2) begin
      return 1;
    end
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// Two-flop synchroniser for the asynchronous Q/Qbar readback.
// Both bits cleared by synchronous reset.
module sr_fb_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Write controller for a NOR SR latch: exclusive S/R pulse,
// guard interval, then synchronised readback check.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GUARD_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  logic req_value,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic done,
  output logic err,
  output logic level,
  output logic level_valid
);

  localparam int CW = cnt_w(PULSE_W, GUARD_W);
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GUARD_W - 1);

  if (PULSE_W < PULSE_W_MIN) begin : g_pw_chk
    $error("PULSE_W below minimum");
  end
  if (GUARD_W < GUARD_W_MIN) begin : g_gw_chk
    $error("GUARD_W below minimum");
  end

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt;
  logic            r_tgt;
  logic            w_tgt;
  logic            r_s;
  logic            r_r;
  logic            r_lvl;
  logic            r_lv;
  logic [1:0]      w_fb_s;
  logic            w_acc;
  logic            w_cnt_z;
  logic            w_mis;
  logic            w_idle;
  logic            w_chk;

  sr_fb_sync u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   ({q_fb, qbar_fb}),
    .o_q   (w_fb_s)
  );

  assign w_idle  = (r_state == IDLE);
  assign w_chk   = (r_state == CHECK);
  assign w_acc   = req_valid && w_idle;
  assign w_cnt_z = (r_cnt == '0);

  // equal Q/Qbar can never satisfy both terms
  assign w_mis = !((w_fb_s[1] == r_tgt) &&
                   (w_fb_s[0] == ~r_tgt));

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_tgt  = r_tgt;
    unique case (1'b1)
      (r_state == IDLE): begin
        if (w_acc) begin
          w_next = PULSE;
          w_cnt  = P_LOAD;
          w_tgt  = req_value;
        end
      end
      (r_state == PULSE): begin
        if (w_cnt_z) begin
          w_next = GUARD;
          w_cnt  = G_LOAD;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      (r_state == GUARD): begin
        if (w_cnt_z) begin
          w_next = CHECK;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      (r_state == CHECK): begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_lvl   <= 1'b0;
      r_lv    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_tgt   <= w_tgt;
      // drives follow next state so S/R line up with PULSE
      r_s     <= (w_next == PULSE) && w_tgt;
      r_r     <= (w_next == PULSE) && !w_tgt;
      if (w_chk) begin
        r_lvl <= r_tgt;
        r_lv  <= !w_mis;
      end else if (w_acc) begin
        r_lv  <= 1'b0;
      end
    end
  end

  assign req_ready   = w_idle;
  assign S           = r_s;
  assign R           = r_r;
  assign done        = w_chk;
  assign err         = w_chk && w_mis;
  assign level       = r_lvl;
  assign level_valid = r_lv;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomised bench: NOR latch model with fault injection and
// a transaction-level schedule model of each write.
module tb_sr_latch_driver;

  localparam int PW   = 2;
  localparam int GW   = 3;
  localparam int NCYC = 4000;

  logic clock = 1'b0;
  logic reset;
  logic req_valid;
  logic req_value;
  logic req_ready;
  logic S;
  logic R;
  logic q_fb;
  logic qbar_fb;
  logic done;
  logic err;
  logic level;
  logic level_valid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sr_latch_driver #(
    .PULSE_W (PW),
    .GUARD_W (GW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .S           (S),
    .R           (R),
    .q_fb        (q_fb),
    .qbar_fb     (qbar_fb),
    .done        (done),
    .err         (err),
    .level       (level),
    .level_valid (level_valid)
  );

  // behavioural NOR latch; fmode overrides the readback
  logic lq = 1'b0;
  int   fmode = 0;

  always @(S or R) begin
    if (S && !R) lq = 1'b1;
    else if (R && !S) lq = 1'b0;
  end

  always_comb begin
    q_fb    = lq;
    qbar_fb = ~lq;
    case (fmode)
      1: begin q_fb = 1'b0; qbar_fb = 1'b1; end
      2: begin q_fb = 1'b0; qbar_fb = 1'b0; end
      3: begin q_fb = 1'b1; qbar_fb = 1'b0; end
      default: ;
    endcase
  end

  task automatic check_eq(
    input string tag,
    input logic  got,
    input logic  exp,
    input int    cyc
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %b want %b",
               tag, cyc, got, exp);
    end
  endtask

  bit qh  [NCYC];
  bit qbh [NCYC];

  initial begin
    bit act;
    int a;
    int p;
    bit tgt;
    bit mlvl;
    bit mlv;
    bit e_s;
    bit e_r;
    bit e_done;
    bit e_err;
    int n_done;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_value = 1'b0;
    act  = 1'b0;
    a    = 0;
    tgt  = 1'b0;
    mlvl = 1'b0;
    mlv  = 1'b0;
    n_done = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      p      = c - a;
      e_s    = act && (p < PW) && tgt;
      e_r    = act && (p < PW) && !tgt;
      e_done = act && (p == PW + GW);
      e_err  = 1'b0;
      if (e_done && c >= 2) begin
        e_err = !((qh[c-2] == tgt) && (qbh[c-2] == !tgt));
      end

      check_eq("ready", req_ready, !act, c);
      check_eq("S", S, e_s, c);
      check_eq("R", R, e_r, c);
      check_eq("excl", S && R, 1'b0, c);
      check_eq("done", done, e_done, c);
      check_eq("err", err, e_err, c);
      check_eq("level", level, mlvl, c);
      check_eq("lvalid", level_valid, mlv, c);
      if (e_done) n_done++;

      reset     = (c < 2) || ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 9) < 6);
      req_value = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0)
          fmode = $urandom_range(1, 3);
        else
          fmode = 0;
      end
      #1;
      qh[c]  = q_fb;
      qbh[c] = qbar_fb;

      if (reset) begin
        act  = 1'b0;
        mlvl = 1'b0;
        mlv  = 1'b0;
      end else if (act && (c - a == PW + GW)) begin
        act  = 1'b0;
        mlvl = tgt;
        mlv  = !e_err;
      end else if (!act && req_valid) begin
        act = 1'b1;
        a   = c + 1;
        tgt = req_value;
        mlv = 1'b0;
      end
    end

    n_chk++;
    if (n_done < 20) begin
      n_err++;
      $display("FAIL writes_completed got %0d want >=20", n_done);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
